// File: rtl/avalon_st_pkt_gen_pkg.sv
// Shared types and length/empty arithmetic for the Avalon-ST packet generator.
package avalon_pkt_gen_pkg;

    localparam int LEN_WIDTH_DEFAULT = 16;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    function automatic int unsigned beats_from_len(input int unsigned len, input int unsigned dw);
        return (len + dw - 1) / dw;
    endfunction

    // Unused symbols on the last beat of a packet of len bytes.
    function automatic int unsigned empty_from_len(input int unsigned len, input int unsigned dw);
        return beats_from_len(len, dw) * dw - len;
    endfunction

endpackage

// File: rtl/avalon_st_pkt_gen_if.sv
// Avalon-ST streaming interface: data/valid/ready with packet framing and empty.
interface avalon_st_if #(
    parameter int DATA_WIDTH_IN_BYTES = 16
) ();
    localparam int EW = $clog2(DATA_WIDTH_IN_BYTES);

    logic [8*DATA_WIDTH_IN_BYTES-1:0] data;
    logic                             valid;
    logic                             ready;
    logic                             sop;
    logic                             eop;
    logic [EW-1:0]                    empty;

    modport master (output data, output valid, output sop, output eop, output empty, input ready);
    modport slave  (input data, input valid, input sop, input eop, input empty, output ready);
endinterface

// File: rtl/avalon_st_pkt_gen_pattern.sv
// Beat builder: fills the leading valid_bytes symbols (MSB first) from seed, zeroes the rest.
// AVALON_PKT_GEN_INCR_PATTERN_EN selects an incrementing byte pattern instead of a constant fill.
module avalon_pkt_gen_pattern #(
    parameter int DATA_WIDTH_IN_BYTES = 16
) (
    input  logic [7:0]                            seed,
    input  logic [$clog2(DATA_WIDTH_IN_BYTES):0]  valid_bytes,
    output logic [8*DATA_WIDTH_IN_BYTES-1:0]      data
);
    localparam int DW = DATA_WIDTH_IN_BYTES;
    localparam int CW = $clog2(DW) + 1;

    always_comb begin
        data = '0;
        for (int i = 0; i < DW; i++) begin
            if (CW'(i) < valid_bytes) begin
`ifdef AVALON_PKT_GEN_INCR_PATTERN_EN
                data[8*(DW-1-i) +: 8] = seed + 8'(i);
`else
                data[8*(DW-1-i) +: 8] = seed;
`endif
            end
        end
    end

endmodule

// File: rtl/avalon_st_pkt_gen.sv
// Avalon-ST packet transmitter: one command in, one framed packet out.
// AVALON_PKT_GEN_INCR_PATTERN_EN switches the payload to an incrementing byte pattern.
module avalon_st_pkt_gen
    import avalon_pkt_gen_pkg::*;
#(
    parameter int DATA_WIDTH_IN_BYTES = 16,
    parameter int LEN_WIDTH           = LEN_WIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [LEN_WIDTH-1:0] cmd_len_bytes,
    input  logic [7:0]           cmd_fill_byte,
    avalon_st_if.master          generated_msg,
    output logic                 busy,
    output logic                 zero_len_error,
    output logic [15:0]          pkt_count
);
    localparam int DW = DATA_WIDTH_IN_BYTES;
    localparam int CW = $clog2(DW) + 1;
    localparam int EW = $clog2(DW);

    state_t               state;
    logic [LEN_WIDTH-1:0] beats_rem;
    logic [LEN_WIDTH-1:0] bytes_rem;
    logic [7:0]           seed_q;
    logic [15:0]          pkt_count_q;
    logic                 zle_q;

    logic [LEN_WIDTH-1:0] beats_cmd;
    logic [CW-1:0]        first_bytes;
    logic [CW-1:0]        next_bytes;
    logic                 next_eop;
    logic [7:0]           pat_seed;
    logic [CW-1:0]        pat_count;
    logic [8*DW-1:0]      pat_data;

    assign cmd_ready      = (state == IDLE);
    assign busy           = (state == SEND);
    assign zero_len_error = zle_q;
    assign pkt_count      = pkt_count_q;

    // beats_rem / bytes_rem count what is still to go after the beat currently on the bus
    assign beats_cmd   = LEN_WIDTH'(beats_from_len(32'(cmd_len_bytes), DW));
    assign first_bytes = (cmd_len_bytes >= LEN_WIDTH'(DW)) ? CW'(DW) : CW'(cmd_len_bytes);
    assign next_bytes  = (bytes_rem >= LEN_WIDTH'(DW)) ? CW'(DW) : CW'(bytes_rem);
    assign next_eop    = (beats_rem == LEN_WIDTH'(1));

    assign pat_seed  = (state == IDLE) ? cmd_fill_byte : seed_q;
    assign pat_count = (state == IDLE) ? first_bytes : next_bytes;

    avalon_pkt_gen_pattern #(
        .DATA_WIDTH_IN_BYTES(DW)
    ) u_pattern (
        .seed       (pat_seed),
        .valid_bytes(pat_count),
        .data       (pat_data)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state                <= IDLE;
            generated_msg.valid  <= 1'b0;
            generated_msg.sop    <= 1'b0;
            generated_msg.eop    <= 1'b0;
            generated_msg.empty  <= '0;
            generated_msg.data   <= '0;
            beats_rem            <= '0;
            bytes_rem            <= '0;
            seed_q               <= '0;
            pkt_count_q          <= '0;
            zle_q                <= 1'b0;
        end else begin
            zle_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_len_bytes == '0) begin
                            zle_q <= 1'b1;
                        end else begin
                            state               <= SEND;
                            generated_msg.valid <= 1'b1;
                            generated_msg.sop   <= 1'b1;
                            generated_msg.eop   <= (beats_cmd == LEN_WIDTH'(1));
                            generated_msg.empty <= (beats_cmd == LEN_WIDTH'(1)) ?
                                                   EW'(empty_from_len(32'(cmd_len_bytes), DW)) : '0;
                            generated_msg.data  <= pat_data;
                            beats_rem           <= beats_cmd - LEN_WIDTH'(1);
                            bytes_rem           <= cmd_len_bytes - LEN_WIDTH'(first_bytes);
`ifdef AVALON_PKT_GEN_INCR_PATTERN_EN
                            seed_q              <= cmd_fill_byte + 8'(DW);
`else
                            seed_q              <= cmd_fill_byte;
`endif
                        end
                    end
                end
                SEND: begin
                    if (generated_msg.ready) begin
                        if (generated_msg.eop) begin
                            state               <= IDLE;
                            generated_msg.valid <= 1'b0;
                            generated_msg.sop   <= 1'b0;
                            generated_msg.eop   <= 1'b0;
                            generated_msg.empty <= '0;
                            generated_msg.data  <= '0;
                            pkt_count_q         <= pkt_count_q + 16'd1;
                        end else begin
                            generated_msg.sop   <= 1'b0;
                            generated_msg.eop   <= next_eop;
                            generated_msg.empty <= next_eop ?
                                                   EW'(empty_from_len(32'(bytes_rem), DW)) : '0;
                            generated_msg.data  <= pat_data;
                            beats_rem           <= beats_rem - LEN_WIDTH'(1);
                            bytes_rem           <= bytes_rem - LEN_WIDTH'(next_bytes);
`ifdef AVALON_PKT_GEN_INCR_PATTERN_EN
                            seed_q              <= seed_q + 8'(DW);
`endif
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_avalon_st_pkt_gen.sv
// Self-checking bench for avalon_st_pkt_gen against a byte-level packet model.
module tb_avalon_st_pkt_gen;
    localparam int DW    = 16;
    localparam int DBITS = 8 * DW;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [15:0] cmd_len_bytes = '0;
    logic [7:0]  cmd_fill_byte = '0;
    logic        busy;
    logic        zero_len_error;
    logic [15:0] pkt_count;

    int tests = 0;
    int fails = 0;
    int exp_cnt = 0;

    avalon_st_if #(.DATA_WIDTH_IN_BYTES(DW)) msg ();

    avalon_st_pkt_gen #(.DATA_WIDTH_IN_BYTES(DW), .LEN_WIDTH(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_len_bytes (cmd_len_bytes),
        .cmd_fill_byte (cmd_fill_byte),
        .generated_msg (msg),
        .busy          (busy),
        .zero_len_error(zero_len_error),
        .pkt_count     (pkt_count)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [DBITS-1:0] obs, input logic [DBITS-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Packet byte n of a command, laid out as a flat byte stream
    function automatic logic [7:0] pkt_byte(input int len, input logic [7:0] fill, input int n);
        if (n >= len) return 8'h00;
`ifdef AVALON_PKT_GEN_INCR_PATTERN_EN
        return 8'((int'(fill) + n) % 256);
`else
        return fill;
`endif
    endfunction

    function automatic logic [DBITS-1:0] exp_beat(input int len, input logic [7:0] fill, input int k);
        logic [DBITS-1:0] r;
        r = '0;
        for (int j = 0; j < DW; j++)
            r[DBITS-1-8*j -: 8] = pkt_byte(len, fill, k*DW + j);
        return r;
    endfunction

    task automatic run_pkt(input int len, input logic [7:0] fill, input int ready_pct,
                           input int stall_beat, input bit hold_cmd);
        int beats;
        int k;
        int cyc;
        int stalls;
        int budget;
        beats  = (len + DW - 1) / DW;
        budget = beats * 40 + 100;
        k      = 0;
        cyc    = 0;
        stalls = 0;
        @(negedge clk);
        chk("idle_cmd_ready", 128'(cmd_ready), 128'(1));
        cmd_valid     = 1'b1;
        cmd_len_bytes = 16'(len);
        cmd_fill_byte = fill;
        msg.ready     = 1'b0;
        @(negedge clk);
        if (hold_cmd) cmd_len_bytes = 16'($urandom_range(1, 100));
        else cmd_valid = 1'b0;
        chk("busy_in_send", 128'(busy), 128'(1));
        chk("cmd_ready_in_send", 128'(cmd_ready), 128'(0));
        while (k < beats && cyc < budget) begin
            chk("valid", 128'(msg.valid), 128'(1));
            chk("sop", 128'(msg.sop), 128'(k == 0));
            chk("eop", 128'(msg.eop), 128'(k == beats - 1));
            chk("empty", 128'(msg.empty), (k == beats - 1) ? 128'(beats*DW - len) : 128'(0));
            chk("data", msg.data, exp_beat(len, fill, k));
            if (k == stall_beat && stalls < 3) begin
                msg.ready = 1'b0;
                stalls++;
            end else begin
                msg.ready = ($urandom_range(0, 99) < ready_pct);
            end
            if (msg.ready) begin
                k++;
                if (k == beats) cmd_valid = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        chk("beats_within_budget", 128'(k), 128'(beats));
        cmd_valid = 1'b0;
        exp_cnt++;
        chk("valid_after_eop", 128'(msg.valid), 128'(0));
        chk("cmd_ready_after_eop", 128'(cmd_ready), 128'(1));
        chk("busy_after_eop", 128'(busy), 128'(0));
        chk("pkt_count", 128'(pkt_count), 128'(16'(exp_cnt)));
    endtask

    initial begin
        msg.ready = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", 128'(msg.valid), 128'(0));
        chk("rst_sop_eop", 128'({msg.sop, msg.eop}), 128'(0));
        chk("rst_data", msg.data, 128'(0));
        chk("rst_empty", 128'(msg.empty), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_zle", 128'(zero_len_error), 128'(0));
        chk("rst_pkt_count", 128'(pkt_count), 128'(0));
        chk("rst_cmd_ready", 128'(cmd_ready), 128'(1));
        rst = 1'b1;

        // single beat, multi-beat, multi-beat with stall on beat 1
        run_pkt(16, 8'h22, 100, -1, 1'b0);
        run_pkt(40, 8'hA5, 100, -1, 1'b0);
        run_pkt(40, 8'h3C, 100, 1, 1'b1);

        // zero-length command
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_len_bytes = 16'd0;
        cmd_fill_byte = 8'h77;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("zle_pulse", 128'(zero_len_error), 128'(1));
        chk("zle_no_valid", 128'(msg.valid), 128'(0));
        chk("zle_cmd_ready", 128'(cmd_ready), 128'(1));
        @(negedge clk);
        chk("zle_single", 128'(zero_len_error), 128'(0));
        chk("zle_no_valid2", 128'(msg.valid), 128'(0));
        chk("zle_pkt_count", 128'(pkt_count), 128'(16'(exp_cnt)));

        // reset in the middle of a 3-beat packet
        cmd_valid = 1'b1;
        cmd_len_bytes = 16'd40;
        cmd_fill_byte = 8'h5A;
        msg.ready = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("abort_beat0_sop", 128'(msg.sop), 128'(1));
        @(negedge clk);
        chk("abort_beat1_sop", 128'(msg.sop), 128'(0));
        chk("abort_beat1_data", msg.data, exp_beat(40, 8'h5A, 1));
        rst = 1'b0;
        @(negedge clk);
        exp_cnt = 0;
        chk("abort_valid", 128'(msg.valid), 128'(0));
        chk("abort_eop", 128'(msg.eop), 128'(0));
        chk("abort_data", msg.data, 128'(0));
        chk("abort_pkt_count", 128'(pkt_count), 128'(0));
        chk("abort_busy", 128'(busy), 128'(0));
        rst = 1'b1;
        @(negedge clk);
        chk("abort_cmd_ready", 128'(cmd_ready), 128'(1));
        chk("abort_still_idle", 128'(msg.valid), 128'(0));
        run_pkt(16, 8'h22, 100, -1, 1'b0);

        // length boundaries
        run_pkt(1, 8'h01, 100, -1, 1'b0);
        run_pkt(15, 8'hF0, 70, -1, 1'b0);
        run_pkt(17, 8'h11, 70, -1, 1'b0);
        run_pkt(32, 8'h80, 50, -1, 1'b1);
        run_pkt(33, 8'h81, 50, 2, 1'b0);
        run_pkt(20, 8'hFE, 100, -1, 1'b0);
        run_pkt(65535, 8'hC3, 100, -1, 1'b0);

        for (int n = 0; n < 25; n++) begin
            int len;
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 16) : $urandom_range(1, 200);
            run_pkt(len, 8'($urandom_range(0, 255)), $urandom_range(30, 100), -1,
                    1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
